// File: rtl/rv32sc_pkg.sv
// Shared RV32 core definitions: next-PC source select codes and fetch FSM states.
package rv32sc_pkg;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;
  localparam logic [1:0] NPC_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection from the resolved write-back source.
// FETCH_MISALIGN_CHECK_EN adds the misaligned flag output.
module pc_next_calc
  import rv32sc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      npc_sel,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jmp_target,
  output logic [XLEN-1:0] next_pc,
  output logic            illegal
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            misaligned
`endif
);

  always_comb begin
    next_pc = pc + XLEN'(4);
    illegal = 1'b0;
    case (npc_sel)
      NPC_SEQ: next_pc = pc + XLEN'(4);
      NPC_BR:  next_pc = br_target;
      NPC_JMP: next_pc = jmp_target;
      default: begin
        next_pc = '0;
        illegal = 1'b1;
      end
    endcase
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = |next_pc[1:0];
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Multi-cycle RV32 front end: owns the PC, fetches one instruction, hands it to decode.
// FETCH_MISALIGN_CHECK_EN adds misalign_err and a terminal HALT state.
module pc_fetch_unit
  import rv32sc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc4,
  input  logic            wb_valid,
  input  logic [1:0]      npc_sel,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jmp_target,
  output logic            illegal_sel
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            req_q;
  logic            valid_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] ipc_q;
  logic [XLEN-1:0] ipc4_q;
  logic            illegal_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc4_d;
  logic            illegal_d;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misaligned_d;
  logic            misalign_q;
`endif

  assign pc4_d = pc_q + XLEN'(4);

  pc_next_calc #(.XLEN(XLEN)) u_next (
    .npc_sel    (npc_sel),
    .pc         (pc_q),
    .br_target  (br_target),
    .jmp_target (jmp_target),
    .next_pc    (pc_d),
    .illegal    (illegal_d)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misaligned (misaligned_d)
`endif
  );

  // The req_q gate on capture drops any ack that arrives in the first cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      ipc_q     <= '0;
      ipc4_q    <= '0;
      illegal_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (req_q && imem_ack) begin
            inst_q  <= imem_rdata;
            ipc_q   <= pc_q;
            ipc4_q  <= pc4_d;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ST_ISSUE;
          end else begin
            req_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (inst_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          if (wb_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (misaligned_d) begin
              misalign_q <= 1'b1;
              state_q    <= ST_HALT;
            end else begin
`else
            begin
`endif
              pc_q      <= pc_d;
              illegal_q <= illegal_d;
              req_q     <= 1'b1;
              state_q   <= ST_FETCH;
            end
          end
        end
        default: begin
`ifndef FETCH_MISALIGN_CHECK_EN
          state_q <= ST_FETCH;
`endif
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign inst_valid  = valid_q;
  assign inst_out    = inst_q;
  assign inst_pc     = ipc_q;
  assign inst_pc4    = ipc4_q;
  assign illegal_sel = illegal_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: random imem latency, decode backpressure and next-PC selects.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        wb_valid;
  logic [1:0]  npc_sel;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic        illegal_sel;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  pc_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_pc4   (inst_pc4),
    .wb_valid   (wb_valid),
    .npc_sel    (npc_sel),
    .br_target  (br_target),
    .jmp_target (jmp_target),
    .illegal_sel(illegal_sel)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int          ready_mode = 0;
  int          hold_low   = 0;
  logic [31:0] exp_pc;
  int          cap_cyc    = 0;
  int          last_cap   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // decode side: ready driver
  initial begin
    inst_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low > 0) begin
        inst_ready = 1'b0;
        if (inst_valid) hold_low--;
      end else if (ready_mode == 0) begin
        inst_ready = 1'b1;
      end else begin
        inst_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // monitor: compares the presented instruction against the scoreboard head
  initial begin
    logic prev_ill;
    exp_t e;
    prev_ill = 1'b0;
    forever begin
      @(negedge clk);
      if (illegal_sel) chk("illegal_one_cycle", 32'(prev_ill), 32'd0);
      prev_ill = illegal_sel;
      if (rst_n && inst_valid) begin
        chk("no_req_while_valid", 32'(imem_req), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_extra: inst_valid with pc %h but nothing expected", inst_pc);
        end else begin
          e = sb[0];
          chk("inst_out", inst_out, e.data);
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_pc4", inst_pc4, e.pc + 32'd4);
          if (inst_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic do_fetch(input int d, output bit ok);
    logic [31:0] w;
    int t;
    ok = 1'b0;
    t  = 0;
    while (!imem_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!imem_req) begin
      fail("fetch_req_timeout");
      return;
    end
    chk("fetch_addr", imem_addr, exp_pc);
    chk("valid_low_in_fetch", 32'(inst_valid), 32'd0);
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_stable", imem_addr, exp_pc);
    end
    w          = $urandom;
    imem_rdata = w;
    imem_ack   = 1'b1;
    sb.push_back('{pc: exp_pc, data: w});
    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    last_cap   = cap_cyc;
    cap_cyc    = cyc;
    chk("valid_after_ack", 32'(inst_valid), 32'd1);
    ok = 1'b1;
  endtask

  // spurious ack/wb_valid while the instruction is being offered
  task automatic do_issue(output bit ok);
    int t;
    ok = 1'b0;
    t  = 0;
    while (inst_valid && t < 60) begin
      imem_ack   = 1'($urandom_range(0, 1));
      wb_valid   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(posedge clk);
      #1;
      t++;
    end
    imem_ack = 1'b0;
    wb_valid = 1'b0;
    if (inst_valid) fail("issue_timeout");
    else ok = 1'b1;
  endtask

  task automatic do_resolve(input logic [1:0] sel, input logic [31:0] br,
                            input logic [31:0] jmp, input int d);
    for (int i = 0; i < d; i++) begin
      chk("req_low_in_resolve", 32'(imem_req), 32'd0);
      @(posedge clk);
      #1;
    end
    npc_sel    = sel;
    br_target  = br;
    jmp_target = jmp;
    wb_valid   = 1'b1;
    @(posedge clk);
    #1;
    wb_valid   = 1'b0;
    npc_sel    = 2'($urandom);
    br_target  = $urandom;
    jmp_target = $urandom;
    chk("illegal_sel", 32'(illegal_sel), 32'(sel == 2'b11));
    chk("req_after_resolve", 32'(imem_req), 32'd1);
    case (sel)
      2'b00:   exp_pc = exp_pc + 32'd4;
      2'b01:   exp_pc = br;
      2'b10:   exp_pc = jmp;
      default: exp_pc = 32'h0;
    endcase
  endtask

  task automatic run_instr(input int d, input int hold, input logic [1:0] sel,
                           input logic [31:0] br, input logic [31:0] jmp,
                           input int dwb, output bit ok);
    hold_low = hold;
    do_fetch(d, ok);
    if (!ok) return;
    do_issue(ok);
    if (!ok) return;
    do_resolve(sel, br, jmp, dwb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // directed prologue: sel, br, jmp, ack delay, ready hold
  logic [1:0]  d_sel [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00};
  logic [31:0] d_br  [10] = '{0, 0, 0, 0, 32'h100, 0, 0, 0, 0, 0};
  logic [31:0] d_jmp [10] = '{0, 0, 0, 0, 0, 32'h40, 0, 32'hFFFF_FFFC, 0, 0};
  int          d_ack [10] = '{0, 0, 0, 5, 0, 1, 0, 2, 0, 0};
  int          d_hold[10] = '{0, 0, 0, 0, 4, 0, 0, 0, 0, 0};

  initial begin
    bit ok;
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    wb_valid   = 1'b0;
    npc_sel    = 2'b00;
    br_target  = 32'h0;
    jmp_target = 32'h0;
    exp_pc     = RST_PC;
    ok         = 1'b1;
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_pc4", inst_pc4, 32'h0);
    chk("rst_illegal", 32'(illegal_sel), 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misalign", 32'(misalign_err), 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 10 && ok; k++) begin
      run_instr(d_ack[k], d_hold[k], d_sel[k], d_br[k], d_jmp[k], 0, ok);
      if (ok && (k == 1 || k == 2)) chk("fetch_spacing", 32'(cap_cyc - last_cap), 32'd3);
    end

    ready_mode = 1;
    for (int k = 0; k < 40 && ok; k++) begin
      run_instr($urandom_range(0, 3), 0, 2'($urandom),
                $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 2), ok);
    end

    if (ok) begin
      // reset while a fetch is outstanding, then a late ack in the first cycle after release
      @(negedge clk);
      chk("prereset_req", 32'(imem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_req_drop", 32'(imem_req), 32'd0);
      chk("async_addr", imem_addr, RST_PC);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("late_ack_ignored", 32'(inst_valid), 32'd0);
      chk("refetch_req", 32'(imem_req), 32'd1);
      imem_ack = 1'b0;
      exp_pc   = RST_PC;
      for (int k = 0; k < 3 && ok; k++) begin
        run_instr($urandom_range(0, 2), 0, 2'b00, 0, 0, 0, ok);
      end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    if (ok) begin
      hold_low = 0;
      do_fetch(0, ok);
      if (ok) do_issue(ok);
      if (ok) begin
        npc_sel   = 2'b01;
        br_target = 32'h102;
        wb_valid  = 1'b1;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        chk("misalign_err", 32'(misalign_err), 32'd1);
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk("halt_no_req", 32'(imem_req), 32'd0);
        end
        chk("misalign_sticky", 32'(misalign_err), 32'd1);
      end
    end
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
